// File: rtl/ram_bank_pkg.sv
// Shared definitions for the two-port RAM bank: sweep FSM states and byte-lane sizing.
package ram_bank_pkg;

  typedef enum logic {
    INIT = 1'b0,
    IDLE = 1'b1
  } bank_state_e;

  localparam int unsigned BYTE_BITS = 8;

  function automatic int unsigned lane_count(input int unsigned data_bit);
    return data_bit / BYTE_BITS;
  endfunction

endpackage

// File: rtl/ram_bank_2p_array.sv
// Byte-enabled storage array with a registered read port; contents are never reset.
module ram_bank_2p_array
  import ram_bank_pkg::*;
#(
  parameter int unsigned ADDR_BIT   = 3,
  parameter int unsigned DATA_BIT   = 16,
  parameter int unsigned MEM_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_BIT-1:0]   wr_addr,
  input  logic [DATA_BIT-1:0]   wr_data,
  input  logic [DATA_BIT/8-1:0] wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_BIT-1:0]   rd_addr,
  output logic [DATA_BIT-1:0]   rd_data
);

  localparam int unsigned LANES = lane_count(DATA_BIT);

  logic [DATA_BIT-1:0] mem [MEM_HEIGHT];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (wr_be[i]) mem[wr_addr][i*BYTE_BITS +: BYTE_BITS] <= wr_data[i*BYTE_BITS +: BYTE_BITS];
      end
    end
  end

  // Same-edge write is not visible here: the read samples the pre-write entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_bank_2p.sv
// Two-port RAM bank with zeroing sweep FSM, address range checks and optional
// read-during-write bypass (define RAM_BANK_2P_BYPASS_EN to return merged new data).
module ram_bank_2p
  import ram_bank_pkg::*;
#(
  parameter int unsigned ADDR_BIT   = 3,
  parameter int unsigned DATA_BIT   = 16,
  parameter int unsigned MEM_HEIGHT = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  we,
  input  logic [ADDR_BIT-1:0]   addr_w,
  input  logic [DATA_BIT-1:0]   d_w,
  input  logic [DATA_BIT/8-1:0] be_w,
  input  logic                  re,
  input  logic [ADDR_BIT-1:0]   addr_r,
  output logic [DATA_BIT-1:0]   d_r,
  output logic                  d_r_valid,
  output logic                  init_busy
);

  localparam int unsigned          LANES  = lane_count(DATA_BIT);
  localparam logic [ADDR_BIT-1:0]  LAST   = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [ADDR_BIT:0]    HEIGHT = (ADDR_BIT + 1)'(MEM_HEIGHT);

  bank_state_e         state, state_nx;
  logic [ADDR_BIT-1:0] cnt, cnt_nx;
  logic                init_wr;
  logic                accept, w_in, r_in, user_wr, user_rd, arr_rd;
  logic                arr_wr;
  logic [ADDR_BIT-1:0] arr_waddr;
  logic [DATA_BIT-1:0] arr_wdata, arr_q, merged;
  logic [LANES-1:0]    arr_be;
  logic                oor_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    init_wr  = 1'b0;
    if (en) begin
      unique case (state)
        INIT: begin
          if (clr) begin
            cnt_nx = '0;
          end else begin
            init_wr = 1'b1;
            if (cnt == LAST) begin
              state_nx = IDLE;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + 1'b1;
            end
          end
        end
        IDLE: begin
          if (clr) begin
            state_nx = INIT;
            cnt_nx   = '0;
          end
        end
        default: state_nx = INIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      init_busy <= (state_nx == INIT);
    end
  end

  // clr in IDLE takes priority and drops any same-cycle read or write.
  assign accept  = en && (state == IDLE) && !clr;
  assign w_in    = {1'b0, addr_w} < HEIGHT;
  assign r_in    = {1'b0, addr_r} < HEIGHT;
  assign user_wr = accept && we && w_in;
  assign user_rd = accept && re;
  assign arr_rd  = user_rd && r_in;

  assign arr_wr    = init_wr || user_wr;
  assign arr_waddr = init_wr ? cnt : addr_w;
  assign arr_wdata = init_wr ? '0  : d_w;
  assign arr_be    = init_wr ? '1  : be_w;

  ram_bank_2p_array #(
    .ADDR_BIT   (ADDR_BIT),
    .DATA_BIT   (DATA_BIT),
    .MEM_HEIGHT (MEM_HEIGHT)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (arr_wr),
    .wr_addr (arr_waddr),
    .wr_data (arr_wdata),
    .wr_be   (arr_be),
    .rd_en   (arr_rd),
    .rd_addr (addr_r),
    .rd_data (arr_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_r_valid <= 1'b0;
      oor_q     <= 1'b0;
    end else begin
      d_r_valid <= user_rd;
      if (user_rd) oor_q <= !r_in;
    end
  end

`ifdef RAM_BANK_2P_BYPASS_EN
  logic                byp_q;
  logic [DATA_BIT-1:0] byp_data_q;
  logic [LANES-1:0]    byp_be_q;

  // Old bytes come from the array's pre-write read; enabled bytes from the captured write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byp_q      <= 1'b0;
      byp_data_q <= '0;
      byp_be_q   <= '0;
    end else if (user_rd) begin
      byp_q      <= user_wr && (addr_w == addr_r);
      byp_data_q <= d_w;
      byp_be_q   <= be_w;
    end
  end

  always_comb begin
    merged = arr_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (byp_q && byp_be_q[i]) merged[i*BYTE_BITS +: BYTE_BITS] = byp_data_q[i*BYTE_BITS +: BYTE_BITS];
    end
  end
`else
  assign merged = arr_q;
`endif

  assign d_r = oor_q ? '0 : merged;

endmodule

// File: tb/tb_ram_bank_2p.sv
// Bench for ram_bank_2p: two instances (8 and 6 entries) against a behavioural model.
module tb_ram_bank_2p;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        en = 1'b0, clr = 1'b0, we = 1'b0, re = 1'b0;
  logic [2:0]  aw = '0, ar = '0;
  logic [15:0] dw = '0;
  logic [1:0]  be = '0;

  logic [15:0] dr8, dr6;
  logic        v8, v6, b8, b6;

  int unsigned total = 0;
  int unsigned bad = 0;

  logic [15:0] m_mem [2][8];
  bit          m_busy [2];
  int unsigned m_cnt [2];
  logic [15:0] m_dr [2];
  bit          m_val [2];
  int unsigned h [2] = '{8, 6};

  always #5 clk = ~clk;

  ram_bank_2p u_dut8 (
    .clk (clk), .rst_n (rst_n), .en (en), .clr (clr), .we (we), .addr_w (aw),
    .d_w (dw), .be_w (be), .re (re), .addr_r (ar),
    .d_r (dr8), .d_r_valid (v8), .init_busy (b8)
  );

  ram_bank_2p #(.MEM_HEIGHT(6)) u_dut6 (
    .clk (clk), .rst_n (rst_n), .en (en), .clr (clr), .we (we), .addr_w (aw),
    .d_w (dw), .be_w (be), .re (re), .addr_r (ar),
    .d_r (dr6), .d_r_valid (v6), .init_busy (b6)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw, input logic [1:0] bb);
    logic [15:0] mask;
    mask = {(bb[1] ? 8'hFF : 8'h00), (bb[0] ? 8'hFF : 8'h00)};
    return (nw & mask) | (old & ~mask);
  endfunction

  task automatic model_step(input int i);
    logic [15:0] rv;
    if (!rst_n) begin
      m_busy[i] = 1; m_cnt[i] = 0; m_dr[i] = '0; m_val[i] = 0;
      return;
    end
    if (!en) begin
      m_val[i] = 0;
      return;
    end
    if (m_busy[i]) begin
      m_val[i] = 0;
      if (clr) m_cnt[i] = 0;
      else begin
        m_mem[i][m_cnt[i]] = '0;
        if (m_cnt[i] == h[i] - 1) begin m_busy[i] = 0; m_cnt[i] = 0; end
        else m_cnt[i]++;
      end
      return;
    end
    if (clr) begin
      m_busy[i] = 1; m_cnt[i] = 0; m_val[i] = 0;
      return;
    end
    m_val[i] = re;
    if (re) begin
      if (ar >= h[i]) rv = '0;
      else begin
        rv = m_mem[i][ar];
`ifdef RAM_BANK_2P_BYPASS_EN
        if (we && aw == ar) rv = merge(rv, dw, be);
`endif
      end
      m_dr[i] = rv;
    end
    if (we && aw < h[i]) m_mem[i][aw] = merge(m_mem[i][aw], dw, be);
  endtask

  task automatic check_all();
    check_eq("d_r8", 32'(dr8), 32'(m_dr[0]));
    check_eq("valid8", 32'(v8), 32'(m_val[0]));
    check_eq("busy8", 32'(b8), 32'(m_busy[0]));
    check_eq("d_r6", 32'(dr6), 32'(m_dr[1]));
    check_eq("valid6", 32'(v6), 32'(m_val[1]));
    check_eq("busy6", 32'(b6), 32'(m_busy[1]));
  endtask

  task automatic step();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    clr = 0; we = 0; re = 0;
  endtask

  task automatic do_wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] b);
    we = 1; aw = a; dw = d; be = b;
    step();
    quiet();
  endtask

  task automatic do_rd(input logic [2:0] a);
    re = 1; ar = a;
    step();
    quiet();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    model_step(0);
    model_step(1);
    check_all();
    step();
    step();
    rst_n = 1;
  endtask

  task automatic count_busy(input string tag);
    int unsigned n = 0;
    for (int k = 0; k < 20; k++) begin
      if (!b8) break;
      n++;
      step();
    end
    check_eq(tag, n, 8);
    while (b6) step();
  endtask

  initial begin
    logic [15:0] exp2;
    #2;
    do_reset();
    check_eq("rst_dr", 32'(dr8), 0);
    check_eq("rst_busy", 32'(b8), 1);
    en = 1;
    count_busy("init_len");

    for (int a = 0; a < 8; a++) begin
      do_rd(3'(a));
      check_eq("init_zero", 32'(dr8), 0);
      check_eq("init_zero_v", 32'(v8), 1);
    end

    do_wr(3'd3, 16'hABCD, 2'b11);
    do_rd(3'd3);
    check_eq("wr_rd3", 32'(dr8), 32'h0000ABCD);
    check_eq("wr_rd3_v", 32'(v8), 1);

    do_wr(3'd5, 16'h1234, 2'b11);
    do_wr(3'd5, 16'hFF00, 2'b10);
    do_rd(3'd5);
    check_eq("be_merge5", 32'(dr8), 32'h0000FF34);

    do_wr(3'd2, 16'h1111, 2'b11);
    we = 1; aw = 3'd2; dw = 16'h2222; be = 2'b11; re = 1; ar = 3'd2;
    step();
    quiet();
`ifdef RAM_BANK_2P_BYPASS_EN
    exp2 = 16'h2222;
`else
    exp2 = 16'h1111;
`endif
    check_eq("rdw_same", 32'(dr8), 32'(exp2));
    step();
    check_eq("idle_valid", 32'(v8), 0);
    check_eq("idle_hold", 32'(dr8), 32'(exp2));

    do_wr(3'd7, 16'hBEEF, 2'b11);
    do_rd(3'd7);
    check_eq("oor_rd", 32'(dr6), 0);
    check_eq("oor_rd_v", 32'(v6), 1);
    for (int a = 0; a < 6; a++) do_rd(3'(a));

    for (int k = 0; k < 400; k++) begin
      en  = ($urandom_range(0, 9) != 0);
      clr = ($urandom_range(0, 59) == 0);
      we  = $urandom_range(0, 1);
      re  = $urandom_range(0, 1);
      aw  = 3'($urandom_range(0, 7));
      ar  = ($urandom_range(0, 3) == 0) ? aw : 3'($urandom_range(0, 7));
      dw  = 16'($urandom());
      be  = 2'($urandom_range(0, 3));
      step();
    end
    quiet();
    en = 1;
    while (b8 || b6) step();

    for (int a = 0; a < 8; a++) do_wr(3'(a), 16'hA500 + 16'(a), 2'b11);
    clr = 1;
    step();
    clr = 0;
    check_eq("clr_busy", 32'(b8), 1);
    step(); step(); step();
    do_reset();
    check_eq("midreset_busy", 32'(b8), 1);
    check_eq("midreset_v", 32'(v8), 0);
    count_busy("resweep_len");
    for (int a = 0; a < 8; a++) begin
      do_rd(3'(a));
      check_eq("resweep_zero", 32'(dr8), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    bad++;
    $display("FAIL timeout: got running want finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule
